// File: rtl/usart_frame_tx.sv
// Buffered 8N1 UART transmitter: frame-start/data strobes feed a circular byte FIFO
// that drains onto Tx_Pin at CLK_FREQ/BAUD clocks per bit, back-to-back with no idle gap.
module usart_frame_tx #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  HEADER     = 8'hA5
) (
    input  logic                          CLOCK_50M,
    input  logic                          RST_n,
    input  logic                          Frame_Start_Sig,
    input  logic                          Data_Send_Sig,
    input  logic [7:0]                    Data,
    output logic                          Tx_Pin,
    output logic                          Busy,
    output logic                          Overflow,
    output logic [$clog2(FIFO_DEPTH):0]   Fifo_Level
);

    localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam int unsigned LW       = AW + 1;
    localparam int unsigned CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    localparam logic [CW-1:0] CNT_ZERO     = CW'(0);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [CW-1:0] CNT_LAST     = CW'(BAUD_DIV - 1);
    localparam logic [LW-1:0] LVL_EMPTY    = LW'(0);
    localparam logic [LW-1:0] LVL_FULL     = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_TWO_FREE = LW'(FIFO_DEPTH - 2);
    localparam logic [AW-1:0] PTR_ONE      = AW'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, wptr_nx_s;
    logic [LW-1:0] lvl_q, lvl_d;
    logic          ovf_q, ovf_d;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic [1:0]    wr_n_s;
    logic          drop_s;
    logic          pop_s;

    assign wptr_nx_s = wptr_q + PTR_ONE;

    // Write side: free space is judged on the start-of-cycle level, so a same-cycle pop never frees room.
    always_comb begin
        mem_d  = mem_q;
        wr_n_s = 2'd0;
        drop_s = 1'b0;
        case ({Frame_Start_Sig, Data_Send_Sig})
            2'b11: begin
                if (lvl_q <= LVL_TWO_FREE) begin
                    mem_d[wptr_q]    = HEADER;
                    mem_d[wptr_nx_s] = Data;
                    wr_n_s           = 2'd2;
                end else if (lvl_q != LVL_FULL) begin
                    mem_d[wptr_q] = HEADER;
                    wr_n_s        = 2'd1;
                    drop_s        = 1'b1;
                end else begin
                    drop_s = 1'b1;
                end
            end
            2'b10: begin
                if (lvl_q != LVL_FULL) begin
                    mem_d[wptr_q] = HEADER;
                    wr_n_s        = 2'd1;
                end else begin
                    drop_s = 1'b1;
                end
            end
            2'b01: begin
                if (lvl_q != LVL_FULL) begin
                    mem_d[wptr_q] = Data;
                    wr_n_s        = 2'd1;
                end else begin
                    drop_s = 1'b1;
                end
            end
            default: begin
                wr_n_s = 2'd0;
            end
        endcase
        wptr_d = wptr_q + AW'(wr_n_s);
        ovf_d  = ovf_q | drop_s;
    end

    // Line FSM: STOP's last cycle pops straight into START so queued bytes leave contiguously.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = CNT_ZERO;
                if (lvl_q != LVL_EMPTY) begin
                    pop_s   = 1'b1;
                    shift_d = mem_q[rptr_q];
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = CNT_ZERO;
                    idx_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = CNT_ZERO;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = CNT_ZERO;
                    if (lvl_q != LVL_EMPTY) begin
                        pop_s   = 1'b1;
                        shift_d = mem_q[rptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d   = CNT_ZERO;
                state_d = S_IDLE;
            end
        endcase
        rptr_d = rptr_q + AW'(pop_s);
        lvl_d  = lvl_q + LW'(wr_n_s) - LW'(pop_s);
    end

    // Output decode from next-state values so the registered pin and Busy line up with the FSM.
    always_comb begin
        case (state_d)
            S_IDLE:  tx_d = 1'b1;
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[idx_d];
            S_STOP:  tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE) || (lvl_d != LVL_EMPTY);
    end

    // State registers; reset drives the line idle-high and discards the queue.
    always_ff @(posedge CLOCK_50M or negedge RST_n) begin
        if (!RST_n) begin
            mem_q   <= '{default: 8'h00};
            wptr_q  <= {AW{1'b0}};
            rptr_q  <= {AW{1'b0}};
            lvl_q   <= LVL_EMPTY;
            ovf_q   <= 1'b0;
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            lvl_q   <= lvl_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign Tx_Pin     = tx_q;
    assign Busy       = busy_q;
    assign Overflow   = ovf_q;
    assign Fifo_Level = lvl_q;

endmodule

// File: tb/tb_usart_frame_tx.sv
// Directed bench: three instances (default, BAUD_DIV=8/depth 16, BAUD_DIV=4/depth 4) share stimulus;
// per-lane line decoders pop expected bytes from scoreboard queues.
module tb_usart_frame_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, fs, ds;
    logic [7:0] data;
    logic       tx0, tx1, tx2, busy0, busy1, busy2, ovf0, ovf1, ovf2;
    logic [4:0] lvl0, lvl1;
    logic [2:0] lvl2;
    logic [2:0] tx_all, busy_all;

    assign tx_all   = {tx2, tx1, tx0};
    assign busy_all = {busy2, busy1, busy0};

    usart_frame_tx u_def (
        .CLOCK_50M(clk), .RST_n(rst_n), .Frame_Start_Sig(fs), .Data_Send_Sig(ds), .Data(data),
        .Tx_Pin(tx0), .Busy(busy0), .Overflow(ovf0), .Fifo_Level(lvl0)
    );

    usart_frame_tx #(.CLK_FREQ(16), .BAUD(2), .FIFO_DEPTH(16)) u_mid (
        .CLOCK_50M(clk), .RST_n(rst_n), .Frame_Start_Sig(fs), .Data_Send_Sig(ds), .Data(data),
        .Tx_Pin(tx1), .Busy(busy1), .Overflow(ovf1), .Fifo_Level(lvl1)
    );

    usart_frame_tx #(.CLK_FREQ(4), .BAUD(1), .FIFO_DEPTH(4)) u_small (
        .CLOCK_50M(clk), .RST_n(rst_n), .Frame_Start_Sig(fs), .Data_Send_Sig(ds), .Data(data),
        .Tx_Pin(tx2), .Busy(busy2), .Overflow(ovf2), .Fifo_Level(lvl2)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [7:0] q0[$], q1[$], q2[$];
    logic [2:0] en = 3'b000;
    int start_prev[3];
    int start_last[3];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int div_of(input int i);
        case (i)
            0:       return 434;
            1:       return 8;
            default: return 4;
        endcase
    endfunction

    function automatic int qsize(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic push(input int i, input logic [7:0] b);
        case (i)
            0:       q0.push_back(b);
            1:       q1.push_back(b);
            default: q2.push_back(b);
        endcase
    endtask

    task automatic take(input int i, output logic [7:0] b);
        case (i)
            0:       b = q0.pop_front();
            1:       b = q1.pop_front();
            default: b = q2.pop_front();
        endcase
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        else if (b == 9) return 1'b1;
        else return d[b-1];
    endfunction

    // Decode one lane at mid-bit points; abandon a frame whenever reset is seen.
    task automatic monitor(input int i);
        int k = -1;
        int st = 0;
        int b;
        int d;
        logic [7:0] sh = 8'h00;
        logic [7:0] e;
        d = div_of(i);
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                k = -1;
            end else if (k < 0) begin
                if (tx_all[i] === 1'b0) begin
                    k = 0;
                    st = cyc;
                end
            end else begin
                k++;
                if (k % d == d / 2) begin
                    b = k / d;
                    if (b >= 1 && b <= 8) begin
                        sh[b-1] = tx_all[i];
                    end else if (b == 9) begin
                        k = -1;
                        start_prev[i] = start_last[i];
                        start_last[i] = st;
                        if (en[i]) begin
                            chk("stop_bit", 32'(tx_all[i]), 32'd1);
                            if (qsize(i) == 0) begin
                                chk("rx_unexpected_byte", 32'(sh), 32'hFFFF_FFFF);
                            end else begin
                                take(i, e);
                                chk("rx_byte", 32'(sh), 32'(e));
                            end
                        end
                    end
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fs = 1'b0;
        ds = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_done(input int i, input int budget);
        int n = 0;
        while ((qsize(i) != 0 || busy_all[i]) && n < budget) begin
            step();
            n++;
        end
        chk("drain_in_budget", 32'(n < budget), 32'd1);
        chk("queue_drained", 32'(qsize(i)), 32'd0);
    endtask

    initial begin
        int peak;
        logic saw_low;
        logic [7:0] b8;
        rst_n = 1'b0;
        fs = 1'b0;
        ds = 1'b0;
        data = 8'h00;
        repeat (2) step();
        chk("rst_tx", 32'(tx0), 32'd1);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_ovf", 32'(ovf0), 32'd0);
        chk("rst_lvl", 32'(lvl0), 32'd0);
        chk("rst_lvl_small", 32'(lvl2), 32'd0);
        rst_n = 1'b1;
        step();

        // Single byte 3C on the default-rate lane, cycle-exact waveform.
        en = 3'b001;
        push(0, 8'h3C);
        data = 8'h3C;
        ds = 1'b1;
        step();
        ds = 1'b0;
        chk("sb_lvl_n1", 32'(lvl0), 32'd1);
        chk("sb_tx_n1", 32'(tx0), 32'd1);
        chk("sb_busy_n1", 32'(busy0), 32'd1);
        step();
        chk("sb_lvl_n2", 32'(lvl0), 32'd0);
        for (int b = 0; b < 10; b++) begin
            chk("sb_bit_first", 32'(tx0), 32'(frame_bit(8'h3C, b)));
            repeat (433) step();
            chk("sb_bit_last", 32'(tx0), 32'(frame_bit(8'h3C, b)));
            if (b == 9) chk("sb_busy_last", 32'(busy0), 32'd1);
            step();
        end
        chk("sb_busy_drop", 32'(busy0), 32'd0);
        chk("sb_tx_idle", 32'(tx0), 32'd1);
        wait_done(0, 1000);

        // Header and data in the same cycle: A5 then 01, contiguous.
        do_reset();
        en = 3'b001;
        push(0, 8'hA5);
        push(0, 8'h01);
        fs = 1'b1;
        ds = 1'b1;
        data = 8'h01;
        step();
        fs = 1'b0;
        ds = 1'b0;
        chk("hd_lvl2", 32'(lvl0), 32'd2);
        step();
        chk("hd_lvl1", 32'(lvl0), 32'd1);
        wait_done(0, 10000);
        chk("hd_gap", 32'(start_last[0] - start_prev[0]), 32'd4340);
        chk("hd_ovf", 32'(ovf0), 32'd0);

        // FIFO fill: 20 strobes, bytes 17..19 dropped.
        do_reset();
        en = 3'b010;
        peak = 0;
        for (int i = 0; i < 20; i++) begin
            data = 8'(i);
            ds = 1'b1;
            if (i <= 16) push(1, 8'(i));
            step();
            if (int'(lvl1) > peak) peak = int'(lvl1);
        end
        ds = 1'b0;
        step();
        if (int'(lvl1) > peak) peak = int'(lvl1);
        chk("fill_peak", 32'(peak), 32'd16);
        chk("fill_ovf", 32'(ovf1), 32'd1);
        wait_done(1, 3000);
        chk("fill_ovf_sticky", 32'(ovf1), 32'd1);
        chk("fill_lvl_end", 32'(lvl1), 32'd0);

        // Wrap-around: 40 bytes each after the previous finished.
        do_reset();
        en = 3'b010;
        for (int i = 0; i < 40; i++) begin
            b8 = 8'(i * 37 + 11);
            push(1, b8);
            data = b8;
            ds = 1'b1;
            step();
            ds = 1'b0;
            wait_done(1, 200);
        end
        chk("wrap_ovf", 32'(ovf1), 32'd0);

        // Reset during data bit 3 with five bytes queued.
        do_reset();
        en = 3'b010;
        for (int i = 0; i < 6; i++) begin
            data = (i == 0) ? 8'hF0 : 8'(i);
            ds = 1'b1;
            step();
        end
        ds = 1'b0;
        repeat (31) step();
        chk("mr_tx_bit3", 32'(tx1), 32'd0);
        chk("mr_lvl_before", 32'(lvl1), 32'd5);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mr_tx_now", 32'(tx1), 32'd1);
        chk("mr_lvl", 32'(lvl1), 32'd0);
        chk("mr_busy", 32'(busy1), 32'd0);
        chk("mr_ovf", 32'(ovf1), 32'd0);
        step();
        rst_n = 1'b1;
        saw_low = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (tx1 !== 1'b1) saw_low = 1'b1;
        end
        chk("mr_no_residual", 32'(saw_low), 32'd0);
        chk("mr_busy_after", 32'(busy1), 32'd0);

        // Depth 4, BAUD_DIV 4: full-with-pop drops the write; 40-cycle bytes.
        do_reset();
        en = 3'b100;
        for (int i = 0; i < 46; i++) begin
            if (i == 41) chk("sm_lvl_41", 32'(lvl2), 32'd4);
            if (i == 42) chk("sm_lvl_42", 32'(lvl2), 32'd3);
            if (i == 43) chk("sm_lvl_43", 32'(lvl2), 32'd4);
            if (i <= 4 || i == 42) push(2, 8'(i));
            data = 8'(i);
            ds = 1'b1;
            step();
        end
        ds = 1'b0;
        chk("sm_ovf", 32'(ovf2), 32'd1);
        wait_done(2, 400);
        chk("sm_spacing", 32'(start_last[2] - start_prev[2]), 32'd40);

        // Depth 4: both strobes with exactly one free entry.
        do_reset();
        en = 3'b100;
        for (int i = 0; i < 4; i++) begin
            push(2, 8'hC0 + 8'(i));
            data = 8'hC0 + 8'(i);
            ds = 1'b1;
            step();
        end
        chk("one_free_lvl", 32'(lvl2), 32'd3);
        chk("one_free_ovf0", 32'(ovf2), 32'd0);
        push(2, 8'hA5);
        fs = 1'b1;
        data = 8'h77;
        step();
        fs = 1'b0;
        ds = 1'b0;
        chk("one_free_lvl_after", 32'(lvl2), 32'd4);
        chk("one_free_ovf1", 32'(ovf2), 32'd1);
        wait_done(2, 400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
